// File: rtl/div_lp_pkg.sv
// Shared types and sizing constants for the div_lp restoring divider.
package div_lp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DIV_LP_WIDTH = 8;
    localparam int DIV_LP_CNT_W = $clog2(DIV_LP_WIDTH + 1);

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_lp_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
module div_lp_step
    import div_lp_pkg::*;
#(
    parameter int W = DIV_LP_WIDTH
) (
    input  logic [W:0]   i_r,
    input  logic         i_bit,
    input  logic [W-1:0] i_div,
    output logic [W:0]   o_r,
    output logic         o_q
);

    logic [W:0] w_t;
    logic       w_unused;

    // R stays below the divisor on valid runs, so its top bit never matters
    assign w_unused = i_r[W];
    assign w_t      = {i_r[W-1:0], i_bit};
    assign o_q      = (w_t >= {1'b0, i_div});
    assign o_r      = o_q ? (w_t - {1'b0, i_div}) : w_t;

endmodule

// File: rtl/div_lp.sv
// Sequential low-power 2W/W unsigned restoring divider, one quotient bit per clock.
// DIV_LP_EARLY_EXIT_EN: divide-by-zero/overflow skip CALC and go straight to DONE.
module div_lp
    import div_lp_pkg::*;
#(
    parameter int WIDTH = DIV_LP_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_zero,
    output logic               overflow
);

    localparam int CW = cnt_w(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH:0]   r_rem;
    logic             r_dz;
    logic             r_ov;
    logic             r_valid;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dz_o;
    logic             r_ov_o;

    logic             w_accept;
    logic             w_dz_in;
    logic             w_ov_in;
    logic             w_last;
    logic             w_to_done;
    logic             w_fin_dz;
    logic             w_fin_ov;
    logic [WIDTH:0]   w_step_r;
    logic             w_qbit;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_dz_in   = (divisor == '0);
    assign w_ov_in   = !w_dz_in && (dividend[2*WIDTH-1:WIDTH] >= divisor);
    assign w_last    = (r_cnt == CW'(1));
    assign w_to_done = (w_next == DONE) && (r_state != DONE);
    // Flags come straight from the inputs when DONE is entered from IDLE
    assign w_fin_dz  = (r_state == IDLE) ? w_dz_in : r_dz;
    assign w_fin_ov  = (r_state == IDLE) ? w_ov_in : r_ov;

    div_lp_step #(
        .W(WIDTH)
    ) u_step (
        .i_r  (r_rem),
        .i_bit(r_shift[WIDTH-1]),
        .i_div(r_div),
        .o_r  (w_step_r),
        .o_q  (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef DIV_LP_EARLY_EXIT_EN
                    w_next = (w_dz_in || w_ov_in) ? DONE : CALC;
`else
                    w_next = CALC;
`endif
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (r_valid && out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_div   <= '0;
            r_shift <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
            r_ov    <= 1'b0;
        end else if (w_accept) begin
            r_div   <= divisor;
            r_shift <= dividend[WIDTH-1:0];
            r_rem   <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
            r_cnt   <= CW'(WIDTH);
            r_dz    <= w_dz_in;
            r_ov    <= w_ov_in;
        end else if (r_state == CALC) begin
            // Quotient bits fill the shift register as dividend bits leave it
            r_rem   <= w_step_r;
            r_shift <= {r_shift[WIDTH-2:0], w_qbit};
            r_cnt   <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz_o  <= 1'b0;
            r_ov_o  <= 1'b0;
        end else begin
            r_valid <= (w_next == DONE);
            if (w_to_done) begin
                if (w_fin_dz || w_fin_ov) begin
                    r_q <= '1;
                    r_r <= '0;
                end else begin
                    r_q <= {r_shift[WIDTH-2:0], w_qbit};
                    r_r <= w_step_r[WIDTH-1:0];
                end
                r_dz_o <= w_fin_dz;
                r_ov_o <= w_fin_ov;
            end
        end
    end

    assign out_valid = r_valid;
    assign quotient  = r_q;
    assign remainder = r_r;
    assign div_zero  = r_dz_o;
    assign overflow  = r_ov_o;

endmodule

// File: doc/div_lp.md
# div_lp

Sequential low-power unsigned divider: the inverse of the team's 8x8 array multiplier. It takes a 2W-bit dividend and a W-bit divisor and returns a W-bit quotient and a W-bit remainder, so a product can be divided back into one of its factors. It uses a restoring algorithm, one quotient bit per clock. Operand registers load only on accept, so the datapath does not toggle while idle.

## Interface
- `WIDTH`, default 8: divisor, quotient and remainder width. The dividend is 2*WIDTH.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: dividend/divisor valid.
- `in_ready` output 1: block can accept. High only in IDLE.
- `dividend` input 2*WIDTH: unsigned dividend.
- `divisor` input WIDTH: unsigned divisor.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer takes result.
- `quotient` output WIDTH: unsigned quotient.
- `remainder` output WIDTH: unsigned remainder.
- `div_zero` output 1: divisor was 0.
- `overflow` output 1: divisor != 0 and dividend[2W-1:W] >= divisor, so the quotient does not fit in W bits.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: iterating.
  - DONE: out_valid=1.
- IDLE -> CALC on `in_valid && in_ready`. That edge latches:
  - the divisor;
  - the low dividend half into the shift register;
  - the partial remainder R (W+1 bits) = {0, dividend[2W-1:W]};
  - the iteration counter = WIDTH;
  - the error flags, computed from the inputs.
- CALC step, one per edge:
  - T = {R[W-1:0], next dividend bit, MSB first}.
  - If T >= divisor: R = T - divisor and the quotient bit is 1. Otherwise R = T and the quotient bit is 0.
  - The counter decrements.
  - The step that brings the counter to 0 also moves the state to DONE.
- DONE -> IDLE on `out_valid && out_ready`. DONE holds all outputs stable while out_ready is low.
- Error results, regardless of configuration: quotient = all-ones, remainder = 0, and the corresponding flag is set. div_zero and overflow are never both 1.
- Valid results satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
- Reset values: in_ready=0 during reset and 1 from the first cycle after reset. out_valid, quotient, remainder, div_zero and overflow are all 0. State is IDLE.
- Reset mid-operation aborts the division. No result is produced, and the block returns to IDLE with reset values.
- The handshake and the result release never occur in the same cycle: in_ready is low in DONE, so there is no back-to-back overlap.

## Timing
- Normal latency: the accept edge plus WIDTH CALC edges. out_valid is first high WIDTH+1 cycles after the handshake cycle, which is 9 cycles for WIDTH=8.
- Throughput: at most one division every WIDTH+2 cycles when out_ready is held high.
- Outputs are registered. There is no combinational path from in_valid/out_ready to any output except through state.
- Output registers update only on entry to DONE. The divisor and shift registers are enabled only on accept and in CALC.

## Configuration
- Macro: `DIV_LP_EARLY_EXIT_EN`.
- Defined: div_zero or overflow detected at accept sends the state IDLE -> DONE directly. out_valid is high 1 cycle after the handshake cycle, and no CALC toggling occurs.
- Undefined: error cases still traverse all WIDTH CALC cycles, so latency is identical to the normal case. The datapath result is discarded and the forced error outputs are presented.

## Structure
- Package `div_lp_pkg`:
  - state enum (IDLE, CALC, DONE);
  - default WIDTH constant;
  - counter width constant = $clog2(WIDTH+1).
- Sub-module `div_lp_step`: purely combinational single restoring step. Inputs R, next bit, divisor. Outputs new R and quotient bit. Instantiated once.
- The top level holds the FSM, counter, registers and handshake.

## Test plan
- 0x3039 / 0x7B (12345/123) -> quotient 0x64, remainder 0x2D, flags 0, out_valid 9 cycles after accept.
- 0xFE01 / 0xFF -> quotient 0xFF, remainder 0x00, no overflow (boundary just below overflow).
- 0x1234 / 0x00 -> div_zero=1, quotient 0xFF, remainder 0. Latency 1 with `DIV_LP_EARLY_EXIT_EN`, 9 without.
- 0x0800 / 0x08 -> overflow=1, div_zero=0, quotient 0xFF, remainder 0.
- 0x0064 / 0x0A with out_ready low for 5 cycles after out_valid:
  - outputs hold 0x0A / 0x00 and in_ready stays 0;
  - release -> IDLE, and the next accept works.
- rst asserted on the 4th CALC cycle:
  - next cycle all outputs 0, in_ready=1, out_valid never asserts;
  - a subsequent 0x3039 / 0x7B yields the correct result.
